// File: rtl/sequenciador_rpn_pilha.sv
// RPN sequencer: operand stack of PROFUNDIDADE words, pops two words into an external ALU and pushes the result back.
// Optional ALU timeout guarded by macro SEQ_RPN_TEMPO_LIMITE_EN.
module sequenciador_rpn_pilha #(
  parameter int LARGURA      = 8,
  parameter int PROFUNDIDADE = 4,
  parameter int TEMPO_LIMITE = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              pulso_empilha,
  input  logic                              pulso_operar,
  input  logic                              pulso_limpar,
  input  logic [LARGURA-1:0]                entrada_dado,
  input  logic [2:0]                        codigo_op,
  input  logic [LARGURA-1:0]                alu_resultado,
  input  logic                              alu_pronto,
  output logic [LARGURA-1:0]                alu_operando_a,
  output logic [LARGURA-1:0]                alu_operando_b,
  output logic [2:0]                        alu_codigo,
  output logic                              alu_inicio,
  output logic [LARGURA-1:0]                topo_pilha,
  output logic [$clog2(PROFUNDIDADE+1)-1:0] contagem,
  output logic                              ocupado,
  output logic                              erro_subfluxo,
  output logic                              erro_transbordo,
  output logic                              erro_tempo
);

  localparam int CW = $clog2(PROFUNDIDADE + 1);
  localparam int IW = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;

  typedef enum logic [1:0] {
    OCIOSO  = 2'b00,
    DISPARA = 2'b01,
    AGUARDA = 2'b10
  } estado_t;

  estado_t            estado;
  logic [LARGURA-1:0] pilha [PROFUNDIDADE];
  logic [CW-1:0]      n;
  logic [IW-1:0]      idx_topo, idx_abaixo, idx_livre;

  // Slot indices derived from the word count; only used when the count makes them valid.
  assign idx_topo   = IW'(n - CW'(1));
  assign idx_abaixo = IW'(n - CW'(2));
  assign idx_livre  = IW'(n);

  assign contagem   = n;
  assign ocupado    = (estado != OCIOSO);
  assign topo_pilha = (n == '0) ? '0 : pilha[idx_topo];

`ifdef SEQ_RPN_TEMPO_LIMITE_EN
  localparam int TW = $clog2(TEMPO_LIMITE + 1);
  logic [TW-1:0] contador;
`else
  assign erro_tempo = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado          <= OCIOSO;
      n               <= '0;
      for (int i = 0; i < PROFUNDIDADE; i++) pilha[i] <= '0;
      alu_operando_a  <= '0;
      alu_operando_b  <= '0;
      alu_codigo      <= '0;
      alu_inicio      <= 1'b0;
      erro_subfluxo   <= 1'b0;
      erro_transbordo <= 1'b0;
`ifdef SEQ_RPN_TEMPO_LIMITE_EN
      erro_tempo      <= 1'b0;
      contador        <= '0;
`endif
    end else if (pulso_limpar) begin
      // Clearing abandons any in-flight operation; stack words keep stale data behind n=0.
      n               <= '0;
      estado          <= OCIOSO;
      alu_inicio      <= 1'b0;
      erro_subfluxo   <= 1'b0;
      erro_transbordo <= 1'b0;
`ifdef SEQ_RPN_TEMPO_LIMITE_EN
      erro_tempo      <= 1'b0;
`endif
    end else begin
      case (estado)
        OCIOSO: begin
          if (pulso_operar) begin
            if (n < CW'(2)) begin
              erro_subfluxo <= 1'b1;
            end else begin
              alu_operando_a <= pilha[idx_abaixo];
              alu_operando_b <= pilha[idx_topo];
              alu_codigo     <= codigo_op;
              alu_inicio     <= 1'b1;
              estado         <= DISPARA;
            end
          end else if (pulso_empilha) begin
            if (n == CW'(PROFUNDIDADE)) begin
              erro_transbordo <= 1'b1;
            end else begin
              pilha[idx_livre] <= entrada_dado;
              n                <= n + CW'(1);
            end
          end
        end
        DISPARA: begin
          alu_inicio <= 1'b0;
          estado     <= AGUARDA;
`ifdef SEQ_RPN_TEMPO_LIMITE_EN
          contador   <= '0;
`endif
        end
        AGUARDA: begin
          // The result replaces the deeper operand, so the pop of two and push of one is a single decrement.
          if (alu_pronto) begin
            pilha[idx_abaixo] <= alu_resultado;
            n                 <= n - CW'(1);
            estado            <= OCIOSO;
          end
`ifdef SEQ_RPN_TEMPO_LIMITE_EN
          else if (contador == TW'(TEMPO_LIMITE - 1)) begin
            erro_tempo <= 1'b1;
            estado     <= OCIOSO;
          end else begin
            contador <= contador + TW'(1);
          end
`endif
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_sequenciador_rpn_pilha.sv
// Directed self-checking bench for sequenciador_rpn_pilha (default parameters).
// Inputs change 1 time unit after the rising edge; outputs are checked at that same point.
module tb_sequenciador_rpn_pilha;

  localparam int LARGURA      = 8;
  localparam int PROFUNDIDADE = 4;
  localparam int TEMPO_LIMITE = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         pulso_empilha = 1'b0;
  logic         pulso_operar = 1'b0;
  logic         pulso_limpar = 1'b0;
  logic [7:0]   entrada_dado = '0;
  logic [2:0]   codigo_op = '0;
  logic [7:0]   alu_resultado = '0;
  logic         alu_pronto = 1'b0;
  logic [7:0]   alu_operando_a, alu_operando_b, topo_pilha;
  logic [2:0]   alu_codigo;
  logic         alu_inicio, ocupado, erro_subfluxo, erro_transbordo, erro_tempo;
  logic [2:0]   contagem;

  int compared = 0;
  int mismatched = 0;
  int n_inicio = 0;

  sequenciador_rpn_pilha #(
    .LARGURA(LARGURA), .PROFUNDIDADE(PROFUNDIDADE), .TEMPO_LIMITE(TEMPO_LIMITE)
  ) dut (
    .clk(clk), .reset(reset),
    .pulso_empilha(pulso_empilha), .pulso_operar(pulso_operar), .pulso_limpar(pulso_limpar),
    .entrada_dado(entrada_dado), .codigo_op(codigo_op),
    .alu_resultado(alu_resultado), .alu_pronto(alu_pronto),
    .alu_operando_a(alu_operando_a), .alu_operando_b(alu_operando_b),
    .alu_codigo(alu_codigo), .alu_inicio(alu_inicio),
    .topo_pilha(topo_pilha), .contagem(contagem), .ocupado(ocupado),
    .erro_subfluxo(erro_subfluxo), .erro_transbordo(erro_transbordo), .erro_tempo(erro_tempo)
  );

  always #5 clk = ~clk;

  // Counts cycles in which the start pulse is seen high.
  always @(posedge clk) if (alu_inicio) n_inicio <= n_inicio + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    pulso_empilha = 1'b1;
    entrada_dado  = v;
    tick();
    pulso_empilha = 1'b0;
  endtask

  task automatic clear();
    pulso_limpar = 1'b1;
    tick();
    pulso_limpar = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    compared++;
    if ({contagem, topo_pilha, ocupado, alu_inicio, erro_subfluxo, erro_transbordo, erro_tempo} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got cnt=%0d topo=%0d ocup=%b ini=%b errs=%b%b%b, want all 0",
               contagem, topo_pilha, ocupado, alu_inicio, erro_subfluxo, erro_transbordo, erro_tempo);
    end
    compared++;
    if ({alu_operando_a, alu_operando_b, alu_codigo} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_alu_outs: got a=%0d b=%0d op=%0d, want 0 0 0", alu_operando_a, alu_operando_b, alu_codigo);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_add();
    int inicio_antes;
    push(8'd5);
    push(8'd3);
    inicio_antes = n_inicio;
    codigo_op    = 3'd1;
    pulso_operar = 1'b1;
    tick();
    pulso_operar = 1'b0;
    compared++;
    if (alu_inicio !== 1'b1 || ocupado !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL add_start: got inicio=%b ocupado=%b, want 1 1", alu_inicio, ocupado);
    end
    compared++;
    if (alu_operando_a !== 8'd5 || alu_operando_b !== 8'd3 || alu_codigo !== 3'd1) begin
      mismatched++;
      $display("[TB] FAIL add_operands: got a=%0d b=%0d op=%0d, want 5 3 1", alu_operando_a, alu_operando_b, alu_codigo);
    end
    tick();
    // Push while busy must be ignored.
    pulso_empilha = 1'b1;
    entrada_dado  = 8'd99;
    tick();
    pulso_empilha = 1'b0;
    compared++;
    if (contagem !== 3'd2 || alu_inicio !== 1'b0 || erro_transbordo !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL busy_push_ignored: got cnt=%0d inicio=%b ovf=%b, want 2 0 0", contagem, alu_inicio, erro_transbordo);
    end
    alu_resultado = 8'd8;
    alu_pronto    = 1'b1;
    tick();
    alu_pronto = 1'b0;
    compared++;
    if (topo_pilha !== 8'd8 || contagem !== 3'd1 || ocupado !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL add_result: got topo=%0d cnt=%0d ocup=%b, want 8 1 0", topo_pilha, contagem, ocupado);
    end
    compared++;
    if (n_inicio - inicio_antes !== 1) begin
      mismatched++;
      $display("[TB] FAIL add_single_pulse: got %0d start pulses, want 1", n_inicio - inicio_antes);
    end
    compared++;
    if (alu_operando_a !== 8'd5 || alu_operando_b !== 8'd3 || erro_tempo !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL add_hold: got a=%0d b=%0d tempo=%b, want 5 3 0", alu_operando_a, alu_operando_b, erro_tempo);
    end
  endtask

  task automatic test_chain();
    clear();
    push(8'd2);
    push(8'd3);
    push(8'd4);
    pulso_operar = 1'b1;
    codigo_op    = 3'd2;
    tick();
    pulso_operar = 1'b0;
    compared++;
    if (alu_operando_a !== 8'd3 || alu_operando_b !== 8'd4 || alu_codigo !== 3'd2) begin
      mismatched++;
      $display("[TB] FAIL mul_operands: got a=%0d b=%0d op=%0d, want 3 4 2", alu_operando_a, alu_operando_b, alu_codigo);
    end
    tick();
    tick();
    alu_resultado = 8'd12;
    alu_pronto    = 1'b1;
    tick();
    alu_pronto = 1'b0;
    compared++;
    if (topo_pilha !== 8'd12 || contagem !== 3'd2) begin
      mismatched++;
      $display("[TB] FAIL mul_result: got topo=%0d cnt=%0d, want 12 2", topo_pilha, contagem);
    end
    pulso_operar = 1'b1;
    codigo_op    = 3'd1;
    tick();
    pulso_operar = 1'b0;
    compared++;
    if (alu_operando_a !== 8'd2 || alu_operando_b !== 8'd12 || alu_inicio !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL add2_operands: got a=%0d b=%0d ini=%b, want 2 12 1", alu_operando_a, alu_operando_b, alu_inicio);
    end
    tick();
    alu_resultado = 8'd14;
    alu_pronto    = 1'b1;
    tick();
    alu_pronto = 1'b0;
    compared++;
    if (topo_pilha !== 8'd14 || contagem !== 3'd1) begin
      mismatched++;
      $display("[TB] FAIL add2_result: got topo=%0d cnt=%0d, want 14 1", topo_pilha, contagem);
    end
  endtask

  task automatic test_underflow();
    int inicio_antes;
    clear();
    push(8'd7);
    inicio_antes = n_inicio;
    pulso_operar = 1'b1;
    tick();
    pulso_operar = 1'b0;
    tick();
    compared++;
    if (erro_subfluxo !== 1'b1 || contagem !== 3'd1 || ocupado !== 1'b0 || n_inicio != inicio_antes) begin
      mismatched++;
      $display("[TB] FAIL underflow: got err=%b cnt=%0d ocup=%b pulses=%0d, want 1 1 0 0",
               erro_subfluxo, contagem, ocupado, n_inicio - inicio_antes);
    end
    // Stray done pulse while idle must not write.
    alu_resultado = 8'd55;
    alu_pronto    = 1'b1;
    tick();
    alu_pronto = 1'b0;
    compared++;
    if (topo_pilha !== 8'd7 || contagem !== 3'd1) begin
      mismatched++;
      $display("[TB] FAIL idle_pronto_ignored: got topo=%0d cnt=%0d, want 7 1", topo_pilha, contagem);
    end
    clear();
    compared++;
    if (erro_subfluxo !== 1'b0 || contagem !== 3'd0 || topo_pilha !== 8'd0) begin
      mismatched++;
      $display("[TB] FAIL underflow_clear: got err=%b cnt=%0d topo=%0d, want 0 0 0", erro_subfluxo, contagem, topo_pilha);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 4; i++) push(8'(i));
    compared++;
    if (erro_transbordo !== 1'b0 || contagem !== 3'd4) begin
      mismatched++;
      $display("[TB] FAIL full_no_error: got ovf=%b cnt=%0d, want 0 4", erro_transbordo, contagem);
    end
    push(8'd5);
    compared++;
    if (erro_transbordo !== 1'b1 || contagem !== 3'd4 || topo_pilha !== 8'd4) begin
      mismatched++;
      $display("[TB] FAIL overflow: got ovf=%b cnt=%0d topo=%0d, want 1 4 4", erro_transbordo, contagem, topo_pilha);
    end
    pulso_empilha = 1'b1;
    pulso_limpar  = 1'b1;
    entrada_dado  = 8'd6;
    tick();
    pulso_empilha = 1'b0;
    pulso_limpar  = 1'b0;
    compared++;
    if (contagem !== 3'd0 || erro_transbordo !== 1'b0 || topo_pilha !== 8'd0) begin
      mismatched++;
      $display("[TB] FAIL limpar_priority: got cnt=%0d ovf=%b topo=%0d, want 0 0 0", contagem, erro_transbordo, topo_pilha);
    end
  endtask

  task automatic test_reset_in_wait();
    push(8'd9);
    push(8'd9);
    pulso_operar = 1'b1;
    tick();
    pulso_operar = 1'b0;
    tick();
    compared++;
    if (ocupado !== 1'b1 || alu_inicio !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL wait_state: got ocup=%b ini=%b, want 1 0", ocupado, alu_inicio);
    end
    #2;
    reset = 1'b1;
    #1;
    compared++;
    if ({contagem, topo_pilha, ocupado, alu_operando_a, alu_operando_b, alu_inicio} !== '0) begin
      mismatched++;
      $display("[TB] FAIL async_reset: got cnt=%0d topo=%0d ocup=%b a=%0d b=%0d, want all 0",
               contagem, topo_pilha, ocupado, alu_operando_a, alu_operando_b);
    end
    @(negedge clk);
    reset = 1'b0;
    alu_resultado = 8'd18;
    alu_pronto    = 1'b1;
    tick();
    alu_pronto = 1'b0;
    tick();
    compared++;
    if (contagem !== 3'd0 || topo_pilha !== 8'd0 || ocupado !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL post_reset_pronto: got cnt=%0d topo=%0d ocup=%b, want 0 0 0", contagem, topo_pilha, ocupado);
    end
  endtask

`ifdef SEQ_RPN_TEMPO_LIMITE_EN
  task automatic test_timeout();
    clear();
    push(8'd6);
    push(8'd7);
    pulso_operar = 1'b1;
    tick();
    pulso_operar = 1'b0;
    tick();
    for (int i = 0; i < TEMPO_LIMITE - 1; i++) tick();
    compared++;
    if (ocupado !== 1'b1 || erro_tempo !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL timeout_early: got ocup=%b tempo=%b, want 1 0", ocupado, erro_tempo);
    end
    tick();
    compared++;
    if (erro_tempo !== 1'b1 || ocupado !== 1'b0 || contagem !== 3'd2 || topo_pilha !== 8'd7) begin
      mismatched++;
      $display("[TB] FAIL timeout: got tempo=%b ocup=%b cnt=%0d topo=%0d, want 1 0 2 7",
               erro_tempo, ocupado, contagem, topo_pilha);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_add();
    test_chain();
    test_underflow();
    test_overflow();
    test_reset_in_wait();
`ifdef SEQ_RPN_TEMPO_LIMITE_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sequenciador_rpn_pilha.md
Name: sequenciador_rpn_pilha

Overview:
Parametrised clocked RPN sequencer for the FPGA ALU datapath. Holds operands on an internal stack of PROFUNDIDADE words, each LARGURA bits wide. On an operate request it pops the two top words, launches the external ALU with a start/done handshake, and pushes the result back. Sits between the debounced button/switch front-end and the ALU. Supersedes the fixed three-step A/B/result sequencer with an arbitrary-depth expression stack.

Parameters:
LARGURA, 8, operand/result width in bits
PROFUNDIDADE, 4, stack depth in words (>=2)
TEMPO_LIMITE, 16, ALU wait limit in cycles (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
pulso_empilha  in  1  one-cycle request: push entrada_dado
pulso_operar  in  1  one-cycle request: apply codigo_op to the top two words
pulso_limpar  in  1  one-cycle request: empty the stack, clear errors, abort any operation
entrada_dado  in  LARGURA  operand to push
codigo_op  in  3  ALU opcode, passed through unchanged
alu_resultado  in  LARGURA  ALU result
alu_pronto  in  1  ALU done; sampled only in AGUARDA
alu_operando_a  out  LARGURA  deeper operand (stack[n-2])
alu_operando_b  out  LARGURA  top operand (stack[n-1])
alu_codigo  out  3  latched opcode
alu_inicio  out  1  one-cycle ALU start pulse
topo_pilha  out  LARGURA  stack[n-1]; 0 when empty
contagem  out  $clog2(PROFUNDIDADE+1)  number of words on the stack (n)
ocupado  out  1  high when not in OCIOSO
erro_subfluxo  out  1  sticky: operate requested with n<2
erro_transbordo  out  1  sticky: push requested with n=PROFUNDIDADE
erro_tempo  out  1  sticky: ALU timeout (feature only; tied 0 otherwise)

Behaviour:
- Reset (asynchronous): state OCIOSO, contagem=0, all stack words=0, all outputs 0. Asserting reset mid-operation aborts the operation without writing a result.
- States: OCIOSO=00, DISPARA=01, AGUARDA=10.
- Priority within a cycle: limpar > operar > empilha.
- limpar (any state): contagem=0, errors cleared, next state OCIOSO, alu_inicio=0. Stack word contents need not be zeroed; topo_pilha reads 0 because n=0.
- OCIOSO, empilha:
  - n<PROFUNDIDADE: stack[n]=entrada_dado and n+=1, visible the next cycle.
  - n=PROFUNDIDADE: set erro_transbordo; stack unchanged.
- OCIOSO, operar:
  - n<2: set erro_subfluxo; stay in OCIOSO.
  - Otherwise: latch alu_operando_a=stack[n-2], alu_operando_b=stack[n-1], alu_codigo=codigo_op; go to DISPARA.
- DISPARA: alu_inicio=1 for exactly this cycle; go to AGUARDA.
- AGUARDA: on alu_pronto, write stack[n-2]=alu_resultado, n-=1, go to OCIOSO.
- Minimum latency: operar at edge k, alu_inicio during cycle k+1, alu_pronto sampled from cycle k+2. The result is visible on topo_pilha the cycle after alu_pronto.
- Operand and opcode outputs stay stable from DISPARA until the next operate is accepted.
- empilha and operar are ignored (no error) while ocupado=1.
- alu_pronto outside AGUARDA is ignored.
- Errors do not block further operation; they clear only on limpar or reset.
- Arithmetic: no width conversion; the result is stored as delivered.

Optional Feature:
Macro SEQ_RPN_TEMPO_LIMITE_EN.
- Defined: a counter runs in AGUARDA. If alu_pronto has not arrived after TEMPO_LIMITE cycles in AGUARDA:
  - set erro_tempo;
  - return to OCIOSO with the stack unchanged (operands not popped).
  - The counter resets on entry to AGUARDA.
- Undefined: no counter; AGUARDA waits indefinitely; erro_tempo is constant 0.

Test Plan:
- Push 5, push 3, operar (ALU model returns 8 two cycles after alu_inicio) -> alu_operando_a=5, alu_operando_b=3, a single alu_inicio pulse, then topo_pilha=8, contagem=1, ocupado=0.
- Push 2,3,4; operar (model: multiply, returns 12); operar (model: add, returns 14) -> intermediate topo_pilha=12 with contagem=2, final topo_pilha=14 with contagem=1.
- Push 7 only, operar -> erro_subfluxo=1, no alu_inicio, contagem=1; then pulso_limpar -> erro_subfluxo=0, contagem=0, topo_pilha=0.
- Push 1,2,3,4,5 with PROFUNDIDADE=4 -> erro_transbordo=1 on the 5th push, contagem=4, topo_pilha=4. Same-cycle empilha+limpar -> contagem=0.
- Push 9,9, operar, assert reset in AGUARDA -> all outputs 0 asynchronously. After release, alu_pronto=1 produces no write; contagem=0.
- With SEQ_RPN_TEMPO_LIMITE_EN, TEMPO_LIMITE=16, ALU never responds -> erro_tempo=1 after 16 AGUARDA cycles, state OCIOSO, contagem=2, topo_pilha unchanged.
